// File: rtl/sound_event_ctrl.sv
// sound_event_ctrl
// Takes N_EVT one-cycle game-event strobes, picks the highest-priority one
// (index 0 first), and plays a square wave with that event's pitch and
// duration. A rising edge on the mute button toggles between muted and
// unmuted. A higher- or equal-priority event restarts a running tone.
//
// Interface timing: evt, tick and mute_btn are plain per-cycle levels that
// are sampled on every rising clk. There is no back-pressure. Events that are
// not accepted on the cycle they are presented are lost.
module sound_event_ctrl #(
    parameter int N_EVT = 4,
    parameter int DIV_W = 16,
    parameter int DUR_W = 12,
    localparam int ID_W = (N_EVT > 1) ? $clog2(N_EVT) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_EVT-1:0]       evt,
    input  logic [N_EVT*DIV_W-1:0] evt_div,
    input  logic [N_EVT*DUR_W-1:0] evt_dur,
    input  logic                   tick,
    input  logic                   mute_btn,
    output logic                   tone_o,
    output logic                   playing,
    output logic [ID_W-1:0]        active_id,
    output logic                   muted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        MUTED = 2'd2
    } state_t;

    state_t            state, state_n;
    logic              btn_q;
    logic              btn_rise;
    logic [DIV_W-1:0]  div_r, div_r_n;
    logic [DIV_W-1:0]  div_cnt, div_cnt_n;
    logic [DUR_W-1:0]  dur_cnt, dur_cnt_n;
    logic              tone_r, tone_n;
    logic [ID_W-1:0]   id_r, id_n;

    logic [ID_W-1:0]   win;
    logic              win_any;
    logic [DIV_W-1:0]  win_div;
    logic [DIV_W-1:0]  win_div_eff;
    logic [DUR_W-1:0]  win_dur;
    logic              accept;
    logic              expiring;
    logic              do_start;

    assign btn_rise = mute_btn & ~btn_q;

    // Fixed-priority pick: the lowest set index wins. Only that winner is considered;
    // a zero-duration winner means nothing is accepted this cycle.
    always_comb begin
        win     = '0;
        win_any = 1'b0;
        for (int i = N_EVT - 1; i >= 0; i--) begin
            if (evt[i]) begin
                win     = ID_W'(i);
                win_any = 1'b1;
            end
        end
        win_div     = evt_div[int'(win) * DIV_W +: DIV_W];
        win_dur     = evt_dur[int'(win) * DUR_W +: DUR_W];
        win_div_eff = (win_div == '0) ? DIV_W'(1) : win_div;
        accept      = win_any && (win_dur != '0);
    end

    // Next-state and datapath update. A mute press beats everything. An event
    // arriving on the expiry edge always takes over, whatever its priority.
    always_comb begin
        state_n   = state;
        div_r_n   = div_r;
        div_cnt_n = div_cnt;
        dur_cnt_n = dur_cnt;
        tone_n    = tone_r;
        id_n      = id_r;

        expiring = (state == PLAY) && tick && (dur_cnt == DUR_W'(1));
        do_start = 1'b0;
        if (!btn_rise && accept) begin
            if (state == IDLE) begin
                do_start = 1'b1;
            end else if (state == PLAY && (win <= id_r || expiring)) begin
                do_start = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                tone_n = 1'b0;
                if (btn_rise) begin
                    state_n = MUTED;
                end
            end
            PLAY: begin
                if (btn_rise) begin
                    state_n   = MUTED;
                    tone_n    = 1'b0;
                    div_cnt_n = '0;
                    dur_cnt_n = '0;
                end else if (expiring) begin
                    state_n   = IDLE;
                    tone_n    = 1'b0;
                    div_cnt_n = '0;
                    dur_cnt_n = '0;
                end else begin
                    if (div_cnt == '0) begin
                        tone_n    = ~tone_r;
                        div_cnt_n = div_r - DIV_W'(1);
                    end else begin
                        div_cnt_n = div_cnt - DIV_W'(1);
                    end
                    if (tick && dur_cnt != '0) begin
                        dur_cnt_n = dur_cnt - DUR_W'(1);
                    end
                end
            end
            MUTED: begin
                tone_n = 1'b0;
                if (btn_rise) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                tone_n  = 1'b0;
            end
        endcase

        // A start overrides the per-state update and ignores tick on this edge.
        if (do_start) begin
            state_n   = PLAY;
            div_r_n   = win_div_eff;
            div_cnt_n = win_div_eff - DIV_W'(1);
            dur_cnt_n = win_dur;
            tone_n    = 1'b0;
            id_n      = win;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            btn_q   <= 1'b0;
            div_r   <= DIV_W'(1);
            div_cnt <= '0;
            dur_cnt <= '0;
            tone_r  <= 1'b0;
            id_r    <= '0;
        end else begin
            state   <= state_n;
            btn_q   <= mute_btn;
            div_r   <= div_r_n;
            div_cnt <= div_cnt_n;
            dur_cnt <= dur_cnt_n;
            tone_r  <= tone_n;
            id_r    <= id_n;
        end
    end

    assign tone_o    = tone_r;
    assign playing   = (state == PLAY);
    assign muted     = (state == MUTED);
    assign active_id = id_r;

endmodule
